// File: rtl/dma_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dma_bus_arbiter_if                                           |
// | Description : Bus bundle between the CPU port, the memory/OAM decoders     |
// |               and the OAM DMA arbiter.                                     |
// |   mstb                  M-cycle strobe (T4 of every M-cycle)               |
// |   cpu_adr/rd/wr/dout    CPU request side        cpu_din  CPU read data     |
// |   mem_adr/rd/wr/dout    external memory bus     mem_din  memory read data  |
// |   oam_adr/dout/wr       OAM write port          dma_active DMA owns bus    |
// |   modport slave  : the arbiter                                             |
// |   modport master : the surrounding system (CPU, memory, OAM)               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface dma_bus_arbiter_if;
  logic        mstb;
  logic [15:0] cpu_adr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic [15:0] mem_adr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic [7:0]  oam_adr;
  logic [7:0]  oam_dout;
  logic        oam_wr;
  logic        dma_active;

  modport slave (
    input  mstb, cpu_adr, cpu_rd, cpu_wr, cpu_dout, mem_din,
    output cpu_din, mem_adr, mem_rd, mem_wr, mem_dout,
           oam_adr, oam_dout, oam_wr, dma_active
  );

  modport master (
    output mstb, cpu_adr, cpu_rd, cpu_wr, cpu_dout, mem_din,
    input  cpu_din, mem_adr, mem_rd, mem_wr, mem_dout,
           oam_adr, oam_dout, oam_wr, dma_active
  );
endinterface
`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dma_bus_arbiter                                              |
// | Description : OAM DMA controller and CPU/DMA arbiter for the shared        |
// |               external memory bus. Owns the DMA source register; a write   |
// |               to it copies OAM_LEN bytes from {src,idx} into OAM while     |
// |               the CPU is restricted to HRAM.                               |
// |   clk      system clock (one per T-cycle)                                  |
// |   reset_n  synchronous, active-low reset                                   |
// |   bus      dma_bus_arbiter_if.slave (CPU, memory and OAM sides)            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dma_bus_arbiter #(
  parameter int          OAM_LEN = 160,
  parameter logic [15:0] DMA_REG = 16'hff46
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  dma_bus_arbiter_if.slave    bus
);

  localparam int                IDX_W      = $clog2(OAM_LEN);
  localparam logic [IDX_W-1:0]  c_idx_last = IDX_W'(OAM_LEN - 1);
  localparam logic [15:0]       c_hram_lo  = 16'hff80;
  localparam logic [15:0]       c_hram_hi  = 16'hfffe;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_src, w_src_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  // Set when the current START was entered from RUN: the bus stays with DMA
  // across a restart, but not across the very first START.
  logic             r_restart, w_restart_nxt;

  logic       w_is_reg, w_is_hram, w_reg_wr, w_run, w_dma_own, w_cpu_fwd;
  logic [7:0] w_idx8;

  assign w_is_reg  = (bus.cpu_adr == DMA_REG);
  assign w_is_hram = (bus.cpu_adr >= c_hram_lo) && (bus.cpu_adr <= c_hram_hi);
  assign w_reg_wr  = bus.cpu_wr && w_is_reg;
  assign w_run     = (r_state == ST_RUN);
  assign w_dma_own = w_run || ((r_state == ST_START) && r_restart);
  assign w_idx8    = 8'(r_idx);
  // CPU access reaches mem_* unless it targets the DMA register or DMA holds
  // the bus and the address is outside HRAM.
  assign w_cpu_fwd = (bus.cpu_rd || bus.cpu_wr) && !w_is_reg &&
                     (!w_dma_own || w_is_hram);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_src     <= 8'hff;
      r_idx     <= '0;
      r_restart <= 1'b0;
    end else if (bus.mstb) begin
      r_state   <= w_state_nxt;
      r_src     <= w_src_nxt;
      r_idx     <= w_idx_nxt;
      r_restart <= w_restart_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_src_nxt     = w_reg_wr ? bus.cpu_dout : r_src;
    w_idx_nxt     = r_idx;
    w_restart_nxt = r_restart;
    case (r_state)
      ST_IDLE: begin
        if (w_reg_wr) begin
          w_state_nxt   = ST_START;
          w_restart_nxt = 1'b0;
        end
      end
      ST_START: begin
        w_idx_nxt   = '0;
        w_state_nxt = w_reg_wr ? ST_START : ST_RUN;
      end
      ST_RUN: begin
        if (w_reg_wr) begin
          // This M-cycle's OAM byte is still written; the copy restarts.
          w_state_nxt   = ST_START;
          w_restart_nxt = 1'b1;
          w_idx_nxt     = '0;
        end else if (r_idx == c_idx_last) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_adr  = 16'h0000;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = 8'h00;
    bus.cpu_din  = 8'hff;
    if (w_dma_own) begin
      bus.mem_adr = {r_src, w_idx8};
      bus.mem_rd  = w_run;
    end
    // An HRAM access during DMA takes the bus for that M-cycle.
    if (w_cpu_fwd) begin
      bus.mem_adr  = bus.cpu_adr;
      bus.mem_rd   = bus.cpu_rd;
      bus.mem_wr   = bus.cpu_wr;
      bus.mem_dout = bus.cpu_dout;
    end
    if (bus.cpu_rd) begin
      if (w_is_reg)       bus.cpu_din = r_src;
      else if (w_cpu_fwd) bus.cpu_din = bus.mem_din;
    end
  end

  // Gating with reset_n keeps a reset that lands on a strobe from writing OAM.
  assign bus.oam_wr     = w_run && bus.mstb && reset_n;
  assign bus.oam_adr    = w_run ? w_idx8 : 8'h00;
  assign bus.oam_dout   = w_run ? bus.mem_din : 8'h00;
  assign bus.dma_active = w_dma_own;

endmodule
`default_nettype wire

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

OAM DMA controller and CPU/DMA arbiter for the shared external memory bus. It owns the `$FF46` DMA register. A CPU write to that register, typically via `LD (n),A` with `n=$46`, starts a 160-byte copy from `{src,$00}..{src,$9F}` into OAM. While the copy runs, the block grants the memory bus to DMA and restricts the CPU to HRAM. It sits between the CPU bus port and the memory/OAM decoders, and advances once per M-cycle.

## Interface
Parameters:
- `OAM_LEN`, default 160: bytes per transfer; the index counter width is `$clog2(OAM_LEN)`.
- `DMA_REG`, default 16'hff46: address of the DMA source register.

Ports:
- `clk` in 1: system clock, one clk per T-cycle.
- `reset_n` in 1: reset, **synchronous and active-low**.
- `mstb` in 1: one-clk pulse on the last T-cycle (T4) of every M-cycle; all state advances only on `mstb`.
- `cpu_adr` in 16: CPU bus address.
- `cpu_rd` in 1: CPU read request, held for the whole M-cycle.
- `cpu_wr` in 1: CPU write request, held for the whole M-cycle.
- `cpu_dout` in 8: CPU write data.
- `cpu_din` out 8: read data returned to the CPU.
- `mem_adr` out 16: memory bus address.
- `mem_rd` out 1: memory bus read enable.
- `mem_wr` out 1: memory bus write enable.
- `mem_dout` out 8: memory bus write data.
- `mem_din` in 8: memory bus read data, valid at `mstb`.
- `oam_adr` out 8: OAM write index.
- `oam_dout` out 8: OAM write data.
- `oam_wr` out 1: OAM write strobe, one clk.
- `dma_active` out 1: high while the bus is owned by DMA.

## Operation
- Register `src[7:0]`:
  - A CPU write to `DMA_REG` latches `cpu_dout` at `mstb`.
  - A CPU read of `DMA_REG` returns `src` in every state.
  - Accesses to `DMA_REG` are never forwarded to `mem_*`.
- HRAM is `$FF80..$FFFE`.
- States and transitions (all taken on `mstb`):
  - **IDLE**: CPU has the bus. All non-`DMA_REG` accesses pass straight through: `mem_*` = `cpu_*` and `cpu_din` = `mem_din`. A `DMA_REG` write moves to START.
  - **START**: one M-cycle delay. `idx`←0, then move to RUN.
  - **RUN**: DMA owns the bus.
    - `mem_adr={src,idx}`, `mem_rd=1`, `mem_wr=0`.
    - At `mstb`: `oam_wr=1`, `oam_adr=idx`, `oam_dout=mem_din`, then `idx`←`idx+1`.
    - After `idx=OAM_LEN-1` is written, move to IDLE.
- CPU side while not IDLE:
  - HRAM accesses pass through.
  - Non-HRAM reads return `$FF`.
  - Non-HRAM writes are dropped.
  - In START, the bus is owned by DMA only if the START was entered from RUN (a restart); a START entered from IDLE leaves the CPU with full access.
- Restart: a `DMA_REG` write in RUN or START latches the new `src`, moves to START and resets `idx`.
  - If the write lands in a RUN M-cycle, that M-cycle's OAM write still completes.
  - No OAM write occurs during START.
- `src` is used unmodified. `mem_adr` is `{src,idx}` even for `src>=$E0`; remapping is the decoder's job.
- `dma_active` = RUN, or START entered from RUN.

## Timing
- Reset values:
  - State IDLE, `src=$FF`, `idx=0`, `dma_active=0`.
  - `oam_wr=0`, `oam_adr=0`, `oam_dout=0`.
  - `mem_rd=0`, `mem_wr=0`, `mem_adr=0`, `mem_dout=0`, `cpu_din=$FF`.
- Reset mid-transfer aborts immediately: no further `oam_wr`, and `dma_active=0` the clk after reset.
- Latency: a `DMA_REG` write in M-cycle k gives START in k+1, the first OAM write at the `mstb` of k+2, and the last OAM write at the `mstb` of k+161.
- `dma_active` rises at the first clk of k+2 and falls at the first clk of k+162; it is high for exactly 160 M-cycles if uninterrupted.
- `oam_wr` is asserted only in the clk where `mstb=1`, and never outside RUN.
- Outputs `mem_*` and `cpu_din` are combinational from the current state and the CPU inputs. State and registers change only on `mstb`.
- A `DMA_REG` write simultaneous with the final RUN M-cycle: byte 159 is written, then START; there is no idle gap.

## Test plan
- **Basic transfer.** CPU writes `$C1` to `$FF46`, with memory returning `mem_adr[7:0]^$5A`:
  - 160 `oam_wr` pulses with `oam_adr` 0..159 and `oam_dout=idx^$5A`.
  - `mem_adr` runs `$C100..$C19F`.
  - `dma_active` is high for exactly 160 M-cycles starting at k+2.
- **CPU reads during RUN.** CPU reads `$C000`: `cpu_din=$FF` and `mem_adr` stays on the DMA address. CPU reads `$FF85`: HRAM data is returned.
- **CPU writes during RUN.** A write of `$8000` produces no `mem_wr`. A write of `$FF90`/`$77` is forwarded with `mem_wr=1`. A read of `$FF46` returns `$C1`.
- **Restart.** Write `$D0` to `$FF46` while `idx=50`:
  - The byte at index 50 is written.
  - One START M-cycle follows with no `oam_wr` and `dma_active=1`.
  - The transfer resumes at `idx` 0 from `$D000`, giving 160 more writes.
- **Reset mid-transfer.** `reset_n=0` during `idx=80`: no `oam_wr` afterwards, `dma_active=0`, and a `$FF46` read returns `$FF`.
- **Idle passthrough.** In IDLE, a write of `$A000`/`$12` gives `mem_wr=1`, `mem_adr=$A000`, `mem_dout=$12`. A write of `$FF46` gives no `mem_wr`.
